// File: rtl/elevator_pkg.sv
// Shared state encoding, default sizing and floor-vector helpers for the elevator scheduler.
// Helpers work on a fixed 32-bit vector; callers zero-extend N-bit floor vectors and truncate results.
package elevator_pkg;
    localparam int N_DEF      = 4;
    localparam int DWELL_DEF  = 3;
    localparam int MAX_FLOORS = 32;

    typedef logic [MAX_FLOORS-1:0] fvec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_t;

    function automatic int onehot_to_idx(input fvec_t v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // Bits strictly above a one-hot position; an all-zero position yields no bits.
    function automatic fvec_t above_mask(input fvec_t v);
        return ~((v << 1) - fvec_t'(1));
    endfunction

    function automatic fvec_t below_mask(input fvec_t v);
        return v - fvec_t'(1);
    endfunction

    function automatic logic is_onehot(input fvec_t v);
        return (v != '0) && ((v & (v - fvec_t'(1))) == '0);
    endfunction
endpackage

// File: rtl/elevator_req_latch.sv
// Pending-request register: merges hall and car presses, clears the served floor on request.
// Press to pending bit is one cycle; here/above/below masks are combinational from the register.
module elevator_req_latch
    import elevator_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_button_out,
    input  logic [N-1:0] i_button_in,
    input  logic [N-1:0] i_current_floor,
    input  logic         i_clr_en,
    output logic [N-1:0] o_pending,
    output logic [N-1:0] o_here,
    output logic [N-1:0] o_above,
    output logic [N-1:0] o_below
);
    logic [N-1:0] r_pending;
    logic [N-1:0] w_clear;

    assign w_clear = i_clr_en ? i_current_floor : '0;

    // Clear wins over a same-cycle press so a press at the served floor is absorbed by the stop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | i_button_out | i_button_in) & ~w_clear;
        end
    end

    assign o_pending = r_pending;
    assign o_here    = r_pending & i_current_floor;
    assign o_above   = r_pending & N'(above_mask(fvec_t'(i_current_floor)));
    assign o_below   = r_pending & N'(below_mask(fvec_t'(i_current_floor)));
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-policy elevator scheduler: latches calls, sequences move/door commands, owns door dwell.
// Moore outputs, registered one cycle after the state decision; an invalid position freezes the FSM.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] button_out,
    input  logic [N-1:0] button_in,
    input  logic [N-1:0] current_floor,
    input  logic         floor_valid,
    output logic         move_up,
    output logic         move_down,
    output logic         door_open,
    output logic [N-1:0] pending,
    output logic         dir_up
);
    localparam int             CW         = $clog2(DWELL + 1);
    localparam logic [CW-1:0]  DWELL_LOAD = CW'(DWELL - 1);

    state_t        r_state;
    state_t        w_nxt;
    logic [CW-1:0] r_dwell;
    logic          r_move_up;
    logic          r_move_down;
    logic          r_door_open;
    logic          r_dir_up;

    logic [N-1:0]  w_here;
    logic [N-1:0]  w_above;
    logic [N-1:0]  w_below;
    logic          w_here_any;
    logic          w_above_any;
    logic          w_below_any;
    logic          w_valid_pos;
    logic          w_at_top;
    logic          w_at_bottom;
    logic          w_restart;
    logic          w_expire;
    logic          w_clr_en;
    int            w_floor_idx;

    assign w_valid_pos = is_onehot(fvec_t'(current_floor));
    assign w_floor_idx = onehot_to_idx(fvec_t'(current_floor));
    assign w_at_top    = (w_floor_idx == N - 1);
    assign w_at_bottom = (w_floor_idx == 0);

    assign w_here_any  = |w_here;
    assign w_above_any = |w_above;
    assign w_below_any = |w_below;

    assign w_restart = (r_state == ST_DOOR) && w_valid_pos
                       && |((button_out | button_in) & current_floor);
    assign w_expire  = (r_state == ST_DOOR) && w_valid_pos && !w_restart && (r_dwell == '0);
    assign w_clr_en  = w_valid_pos && ((r_state == ST_DOOR) || (w_nxt == ST_DOOR));

    elevator_req_latch #(
        .N (N)
    ) u_req_latch (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_button_out    (button_out),
        .i_button_in     (button_in),
        .i_current_floor (current_floor),
        .i_clr_en        (w_clr_en),
        .o_pending       (pending),
        .o_here          (w_here),
        .o_above         (w_above),
        .o_below         (w_below)
    );

    always_comb begin
        w_nxt = r_state;
        if (w_valid_pos) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_here_any)       w_nxt = ST_DOOR;
                    else if (w_above_any) w_nxt = ST_UP;
                    else if (w_below_any) w_nxt = ST_DOWN;
                end
                ST_UP: begin
                    if (floor_valid) begin
                        if (w_here_any)        w_nxt = ST_DOOR;
                        else if (!w_above_any) w_nxt = w_below_any ? ST_DOWN : ST_IDLE;
                    end
                end
                ST_DOWN: begin
                    if (floor_valid) begin
                        if (w_here_any)        w_nxt = ST_DOOR;
                        else if (!w_below_any) w_nxt = w_above_any ? ST_UP : ST_IDLE;
                    end
                end
                ST_DOOR: begin
                    // Keep sweeping the current direction before reversing.
                    if (w_expire) begin
                        if (r_dir_up)
                            w_nxt = w_above_any ? ST_UP : (w_below_any ? ST_DOWN : ST_IDLE);
                        else
                            w_nxt = w_below_any ? ST_DOWN : (w_above_any ? ST_UP : ST_IDLE);
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dwell     <= '0;
            r_move_up   <= 1'b0;
            r_move_down <= 1'b0;
            r_door_open <= 1'b0;
            r_dir_up    <= 1'b1;
        end else begin
            r_state <= w_nxt;

            if (w_valid_pos && (w_nxt == ST_DOOR) && ((r_state != ST_DOOR) || w_restart))
                r_dwell <= DWELL_LOAD;
            else if ((r_state == ST_DOOR) && w_valid_pos && (r_dwell != '0))
                r_dwell <= r_dwell - CW'(1);

            if (w_nxt == ST_UP)        r_dir_up <= 1'b1;
            else if (w_nxt == ST_DOWN) r_dir_up <= 1'b0;

            r_move_up   <= w_valid_pos && (w_nxt == ST_UP)   && !w_at_top;
            r_move_down <= w_valid_pos && (w_nxt == ST_DOWN) && !w_at_bottom;
            r_door_open <= w_valid_pos && (w_nxt == ST_DOOR);
        end
    end

    assign move_up   = r_move_up;
    assign move_down = r_move_down;
    assign door_open = r_door_open;
    assign dir_up    = r_dir_up;
endmodule
